sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Each granted transaction runs IDLE -> SETUP -> ACCESS, three cycles long.
module sram_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   output logic              sram_wr_en,
   input  logic [DATA_W-1:0] sram_dout
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t state;
   state_t state_nx;

   logic last_served;
   logic owner;
   logic we_q;
   logic win;
   logic grant;

   // A tie goes to the port that was not served last.
   always_comb begin
      win = 1'b0;
      priority case (1'b1)
         req0 && req1: win = ~last_served;
         req1:         win = 1'b1;
         default:      win = 1'b0;
      endcase
   end

   assign grant = (state == IDLE) && (req0 || req1);
   assign busy  = (state != IDLE);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (grant) state_nx = SETUP;
         SETUP:   state_nx = ACCESS;
         ACCESS:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         sram_addr   <= '0;
         sram_din    <= '0;
         sram_wr_en  <= 1'b0;
         we_q        <= 1'b0;
         owner       <= 1'b0;
         last_served <= 1'b1;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant) begin
                  owner       <= win;
                  last_served <= win;
                  we_q        <= win ? we1 : we0;
                  sram_addr   <= win ? addr1 : addr0;
                  sram_din    <= win ? wdata1 : wdata0;
                  gnt0        <= ~win;
                  gnt1        <= win;
               end
            end
            SETUP: begin
               sram_wr_en <= we_q;
            end
            ACCESS: begin
               sram_wr_en <= 1'b0;
               done0      <= ~owner;
               done1      <= owner;
               if (!we_q) begin
                  if (owner) rdata1 <= sram_dout;
                  else       rdata0 <= sram_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_sram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [4:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [31:0] rdata0, rdata1;
   logic [4:0]  sram_addr;
   logic [31:0] sram_din;
   logic        sram_wr_en;
   logic [31:0] sram_dout;

   sram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_wr_en(sram_wr_en), .sram_dout(sram_dout)
   );

   logic [31:0] sram [32] = '{default: 32'h0};
   always @(posedge clk) if (sram_wr_en) sram[sram_addr] <= sram_din;
   assign sram_dout = sram[sram_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: g is the cycle in which the latest grant is visible.
   logic [31:0] ref_mem [32] = '{default: 32'h0};
   logic [31:0] exp_rd [2];
   int          n = 0;
   int          g = -100;
   int          gp = 0;
   int          last = 1;
   logic        gwe = 1'b0;
   logic [4:0]  gaddr = '0;
   logic [31:0] gdata = '0;
   bit          auto_drop = 1'b1;

   int gq[$];
   int gc[$];
   int wq[$];
   int t_done0 = -1;
   int t_gnt1 = -1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      n++;
      if (n == g + 2) begin
         if (gwe) ref_mem[gaddr] = gdata;
         else     exp_rd[gp] = ref_mem[gaddr];
      end
      if (n >= g + 3 && (req0 || req1)) begin
         if (req0 && req1) gp = (last == 0) ? 1 : 0;
         else              gp = req1 ? 1 : 0;
         g     = n;
         last  = gp;
         gwe   = gp ? we1 : we0;
         gaddr = gp ? addr1 : addr0;
         gdata = gp ? wdata1 : wdata0;
      end
      chk("gnt0", gnt0, n == g && gp == 0);
      chk("gnt1", gnt1, n == g && gp == 1);
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("done0", done0, n == g + 2 && gp == 0);
      chk("done1", done1, n == g + 2 && gp == 1);
      chk("busy", busy, n == g || n == g + 1);
      chk("wr_en", sram_wr_en, n == g + 1 && gwe);
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      if (n >= g && n <= g + 2) begin
         chk("sram_addr", sram_addr, gaddr);
         chk("sram_din", sram_din, gdata);
      end
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (gnt0 || gnt1) gc.push_back(n);
      if (sram_wr_en) wq.push_back(n);
      if (done0) t_done0 = n;
      if (gnt1) t_gnt1 = n;
      if (n == g && auto_drop) begin
         if (gp == 0) req0 = 1'b0;
         else         req1 = 1'b0;
      end
   endtask

   task automatic do_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_wr_en", sram_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {gnt0, gnt1}, 0);
      chk("rst_done", {done0, done1}, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_din", sram_din, 0);
      g = -100;
      last = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic xact(input int p, input logic w, input logic [4:0] a,
                       input logic [31:0] d);
      if (p == 0) begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
      end
      for (int i = 0; i < 20; i++) begin
         step();
         if (p == 0 ? !req0 : !req1) break;
      end
      step();
      step();
   endtask

   function automatic logic [4:0] pick_addr();
      case ($urandom_range(3))
         0:       return 5'd0;
         1:       return 5'd31;
         default: return 5'($urandom_range(31));
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      do_reset();

      wq.delete(); gc.delete();
      xact(0, 1'b1, 5'd5, 32'hDEADBEEF);
      chk("w_count", wq.size(), 1);
      if (wq.size() > 0 && gc.size() > 0) chk("w_cycle", wq[0] - gc[0], 1);
      xact(1, 1'b0, 5'd5, 32'h0);
      chk("rd_deadbeef", rdata1, 32'hDEADBEEF);
      chk("rdata0_kept", rdata0, 32'h0);

      do_reset();
      gq.delete(); gc.delete();
      auto_drop = 1'b0;
      we0 = 0; we1 = 0; addr0 = 5'd5; addr1 = 5'd5;
      req0 = 1'b1; req1 = 1'b1;
      repeat (14) step();
      auto_drop = 1'b1;
      chk("rr_count", gq.size() >= 4, 1);
      if (gq.size() >= 4) begin
         chk("rr_0", gq[0], 0);
         chk("rr_1", gq[1], 1);
         chk("rr_2", gq[2], 0);
         chk("rr_3", gq[3], 1);
         for (int i = 0; i < 3; i++) chk("rr_gap", gc[i+1] - gc[i], 3);
      end

      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd9; wdata0 = 32'h12345678;
      for (int i = 0; i < 10; i++) begin
         step();
         if (n == g + 1) break;
      end
      chk("pre_abort_wr_en", sram_wr_en, 1);
      do_reset();
      gq.delete();
      we0 = 0; we1 = 0; addr0 = 5'd9; addr1 = 5'd9;
      req0 = 1'b1; req1 = 1'b1;
      repeat (8) step();
      chk("tie_after_reset", gq.size() > 0 ? gq[0] : -1, 0);
      chk("aborted_write", rdata0, 32'h0);

      t_done0 = -1; t_gnt1 = -1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
      for (int i = 0; i < 10; i++) begin
         step();
         if (n == g) break;
      end
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
      repeat (6) step();
      chk("late_req_gap", t_gnt1 - t_done0, 1);

      xact(0, 1'b1, 5'd0, 32'hA5A5_0000);
      xact(1, 1'b1, 5'd31, 32'h5A5A_FFFF);
      xact(1, 1'b0, 5'd0, 32'h0);
      chk("rd_addr0", rdata1, 32'hA5A5_0000);
      xact(0, 1'b0, 5'd31, 32'h0);
      chk("rd_addr31", rdata0, 32'h5A5A_FFFF);

      for (int c = 0; c < 400; c++) begin
         step();
         if (!req0 && $urandom_range(2) == 0) begin
            req0 = 1'b1; we0 = 1'($urandom_range(1));
            addr0 = pick_addr(); wdata0 = $urandom;
         end
         if (!req1 && $urandom_range(2) == 0) begin
            req1 = 1'b1; we1 = 1'($urandom_range(1));
            addr1 = pick_addr(); wdata1 = $urandom;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
